// File: rtl/comparator_exerciser.sv
// Walks all 16 four-bit vectors through an external comparator, holds each for SETTLE+1 cycles,
// compares out1 against a truth table and records the error count and first failing vector.
module comparator_exerciser #(
  parameter logic [15:0] EXPECTED = 16'h8421,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       in4,
  input  logic       out1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] HoldLast = 4'(SETTLE);

  state_e     state_q;
  logic [3:0] vec_q;
  logic [3:0] hold_q;
  logic [3:0] drive_q;
  logic [3:0] ffv_q;
  logic [4:0] err_q;
  logic       ffvld_q;
  logic       busy_q;
  logic       done_q;
  logic       sample;
  logic       mismatch;

  // out1 is only consumed at the edge ending the last hold cycle of a vector.
  assign sample   = (state_q == StRun) && (hold_q == HoldLast);
  assign mismatch = sample && (out1 != EXPECTED[vec_q]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 4'd0;
      hold_q  <= 4'd0;
      drive_q <= 4'd0;
      ffv_q   <= 4'd0;
      err_q   <= 5'd0;
      ffvld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StRun;
            vec_q   <= 4'd0;
            hold_q  <= 4'd0;
            drive_q <= 4'd0;
            ffv_q   <= 4'd0;
            err_q   <= 5'd0;
            ffvld_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (sample) begin
            if (mismatch) begin
              err_q <= err_q + 5'd1;
              if (!ffvld_q) begin
                ffvld_q <= 1'b1;
                ffv_q   <= vec_q;
              end
            end
            hold_q <= 4'd0;
            if (vec_q != 4'hF) begin
              vec_q   <= vec_q + 4'd1;
              drive_q <= vec_q + 4'd1;
            end else begin
              state_q <= StDone;
              drive_q <= 4'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign {in1, in2, in3, in4} = drive_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (err_q == 5'd0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvld_q;

endmodule

// File: doc/comparator_exerciser.md
COMPARATOR_EXERCISER -- requirements
Module: comparator_exerciser

Interface
REQ-001 Parameter EXPECTED, default 16'h8421, truth table of the device under test. Bit index is {in1,in2,in3,in4}; the default encodes 2-bit equality {in1,in2}=={in3,in4}.
REQ-002 Parameter SETTLE, default 2, range 0..15: extra hold cycles per vector before out1 is sampled.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 in1  output  1  vector bit 3 (MSB) driven to the comparator.
REQ-008 in2  output  1  vector bit 2.
REQ-009 in3  output  1  vector bit 1.
REQ-010 in4  output  1  vector bit 0 (LSB).
REQ-011 out1  input  1  comparator result, treated as combinational from in1..in4.
REQ-012 busy  output  1  high while vectors are being applied.
REQ-013 done  output  1  high (level) in DONE.
REQ-014 pass  output  1  done && err_count==0.
REQ-015 err_count  output  5  number of mismatching vectors, 0..16.
REQ-016 first_fail_vec  output  4  {in1,in2,in3,in4} of the first mismatch.
REQ-017 first_fail_valid  output  1  first_fail_vec holds a captured mismatch.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 IDLE or DONE, start=1: next cycle is RUN with vec=0, hold counter=0, err_count=0, first_fail_valid=0, first_fail_vec=0, done=0.
REQ-020 in1..in4 SHALL be registered copies of vec[3:0]; they change only on vector advance, on start, or on reset.
REQ-021 Each vector SHALL be held for exactly SETTLE+1 cycles; out1 SHALL be sampled at the clock edge ending the last hold cycle.
REQ-022 Sample edge, out1 != EXPECTED[vec]: err_count SHALL increment by 1, with no saturation needed (maximum 16).
REQ-023 Sample edge, mismatch with first_fail_valid=0: first_fail_vec<=vec and first_fail_valid<=1; later mismatches SHALL NOT overwrite either.
REQ-024 Sample edge, vec<15: vec increments and the hold counter clears.
REQ-025 Sample edge, vec==15: next state is DONE and in1..in4 return to 0.
REQ-026 Full run latency: busy SHALL be high for exactly 16*(SETTLE+1) cycles, starting the cycle after start is sampled; done SHALL rise the cycle busy falls.
REQ-027 start SHALL be ignored while in RUN.
REQ-028 DONE SHALL hold err_count, first_fail_* and pass stable until start or rst.
REQ-029 Outputs in1..in4, busy, done and pass SHALL be registered or derived only from registered state.
REQ-030 out1 SHALL feed no output combinationally.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE; in1..in4=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_valid=0; vec=0; hold counter=0.
REQ-032 rst SHALL take priority over start in every state, including mid-RUN.
REQ-033 After rst deasserts, no run SHALL begin until a new start.

Verification
REQ-034 SETTLE=2, out1 driven by an equality model -> start; busy high 48 cycles; then done=1, pass=1, err_count=0, first_fail_valid=0.
REQ-035 out1 tied 0 -> err_count=4, first_fail_vec=4'b0000, first_fail_valid=1, pass=0.
REQ-036 out1 tied 1 -> err_count=12, first_fail_vec=4'b0001, pass=0.
REQ-037 rst pulsed while vec=7 -> next cycle busy=0, in1..in4=0, err_count=0; a new start then runs the full 48 cycles.
REQ-038 start held high through RUN -> no restart, still 48 busy cycles; start pulsed in DONE -> done=0 next cycle, counters cleared, vec=0.
REQ-039 SETTLE=0 with the equality model -> busy high 16 cycles, each vector held 1 cycle, pass=1.
